// File: rtl/scarf_pkg.sv
// Shared SCARF SPI definitions: front-end FSM states and byte framing constants.
package scarf_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ID_BYTE   = 2'd1,
        DATA_BYTE = 2'd2
    } scarf_spi_state_t;

    localparam int SCARF_BYTE_BITS = 8;
    localparam logic [2:0] SCARF_LAST_BIT = 3'(SCARF_BYTE_BITS - 1);

    // True when the bit counter shows the current rise carries the final bit of a byte.
    function automatic logic is_last_bit(input logic [2:0] cnt);
        return (cnt == SCARF_LAST_BIT);
    endfunction

endpackage

// File: rtl/scarf_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with a selectable reset level.
module scarf_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_r;

    // Shift the raw pin through the chain; the last stage is the safe copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            chain_r <= {chain_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/scarf_spi_oversampled_slave.sv
// Oversampling SPI mode-0 slave front end: decodes the ID byte, delivers data bytes
// to every SCARF slave and serialises the OR-ed slave read data back onto MISO.
import scarf_pkg::*;

module scarf_spi_oversampled_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    output logic       miso,
    output logic       miso_oe,
    output logic [7:0] data_in,
    output logic       data_in_valid,
    output logic       data_in_finished,
    output logic [6:0] slave_id,
    output logic       rnw,
    input  logic [7:0] read_data_in
);

    logic sclk_s;
    logic mosi_s;
    logic cs_n_s;
    logic sclk_d_r;
    logic cs_n_d_r;
    logic sclk_rise_s;
    logic sclk_fall_s;
    logic cs_fall_s;
    logic cs_rise_s;
    logic byte_done_s;
    logic oe_s;
    logic [7:0] rx_byte_s;

    scarf_spi_state_t state_r;
    scarf_spi_state_t state_next_s;
    logic [2:0] bit_cnt_r;
    logic [6:0] shift_r;
    logic [7:0] tx_r;

    scarf_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
    scarf_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));
    scarf_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_n_s));

    // Delayed copies of the synced pins for edge detection; reset to idle bus levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d_r <= 1'b0;
            cs_n_d_r <= 1'b1;
        end else begin
            sclk_d_r <= sclk_s;
            cs_n_d_r <= cs_n_s;
        end
    end

    assign sclk_rise_s = sclk_s & ~sclk_d_r;
    assign sclk_fall_s = ~sclk_s & sclk_d_r;
    assign cs_fall_s   = ~cs_n_s & cs_n_d_r;
    assign cs_rise_s   = cs_n_s & ~cs_n_d_r;
    assign byte_done_s = (state_r != IDLE) && sclk_rise_s && is_last_bit(bit_cnt_r);
    assign rx_byte_s   = {shift_r, mosi_s};
    assign oe_s        = (state_r == DATA_BYTE) && rnw && !cs_n_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state; cs_rise wins over a completing byte, which is still accepted below.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (cs_fall_s) begin
                    state_next_s = ID_BYTE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ID_BYTE: begin
                if (cs_rise_s) begin
                    state_next_s = IDLE;
                end else if (byte_done_s) begin
                    state_next_s = DATA_BYTE;
                end else begin
                    state_next_s = ID_BYTE;
                end
            end
            DATA_BYTE: begin
                if (cs_rise_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DATA_BYTE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Receive path: bit counting, ID/data byte capture and the one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r        <= 3'd0;
            shift_r          <= 7'd0;
            data_in          <= 8'd0;
            data_in_valid    <= 1'b0;
            data_in_finished <= 1'b0;
            slave_id         <= 7'd0;
            rnw              <= 1'b0;
        end else begin
            data_in_valid    <= 1'b0;
            data_in_finished <= 1'b0;
            if (state_r == IDLE) begin
                if (cs_fall_s) begin
                    bit_cnt_r <= 3'd0;
                end
            end else begin
                if (byte_done_s) begin
                    bit_cnt_r <= 3'd0;
                    if (state_r == ID_BYTE) begin
                        rnw      <= rx_byte_s[7];
                        slave_id <= rx_byte_s[6:0];
                    end else begin
                        data_in       <= rx_byte_s;
                        data_in_valid <= 1'b1;
                    end
                end else if (sclk_rise_s) begin
                    shift_r   <= {shift_r[5:0], mosi_s};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
                // A partial byte is dropped simply by restarting the count.
                if (cs_rise_s) begin
                    data_in_finished <= 1'b1;
                    bit_cnt_r        <= 3'd0;
                end
            end
        end
    end

    // Transmit path: reload at each byte boundary, otherwise shift on falling sclk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r <= 8'd0;
        end else begin
            if ((state_r == DATA_BYTE) && sclk_fall_s) begin
                if (bit_cnt_r == 3'd0) begin
                    tx_r <= read_data_in;
                end else begin
                    tx_r <= {tx_r[6:0], 1'b0};
                end
            end
        end
    end

    // Registered pad drive; MISO is held low whenever the pad is not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
        end else begin
            miso    <= oe_s & tx_r[7];
            miso_oe <= oe_s;
        end
    end

endmodule

// File: tb/tb_scarf_spi_oversampled_slave.sv
// Directed and randomized bench for the SCARF SPI slave front end, acting as SPI master
// and as the OR-ed slave responder on read_data_in.
module tb_scarf_spi_oversampled_slave;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       miso;
    logic       miso_oe;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_finished;
    logic [6:0] slave_id;
    logic       rnw;
    logic [7:0] read_data_in;

    int total = 0;
    int bad = 0;
    int fin_cnt = 0;
    int both_cnt = 0;
    bit echo_mode = 1'b0;
    logic [7:0] resp_val = 8'h00;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] miso_q[$];
    logic [7:0] oe_q[$];

    scarf_spi_oversampled_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .miso(miso), .miso_oe(miso_oe), .data_in(data_in),
        .data_in_valid(data_in_valid), .data_in_finished(data_in_finished),
        .slave_id(slave_id), .rnw(rnw), .read_data_in(read_data_in));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clk step; observe pulses on the falling edge and answer as the slave side.
    task automatic tick();
        @(negedge clk);
        if (data_in_valid === 1'b1) begin
            rx_q.push_back(data_in);
            if (data_in_finished === 1'b1) both_cnt++;
            read_data_in = echo_mode ? (data_in ^ 8'h5A) : resp_val;
        end
        if (data_in_finished === 1'b1) fin_cnt++;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nb, input bit align_last,
                             output logic [7:0] rb, output logic [7:0] ob);
        rb = 8'h00;
        ob = 8'h00;
        for (int i = 0; i < nb; i++) begin
            mosi = b[7-i];
            repeat (5) tick();
            rb[7-i] = miso;
            ob[7-i] = miso_oe;
            sclk = 1'b1;
            if (align_last && i == nb - 1) cs_n = 1'b1;
            repeat (5) tick();
            sclk = 1'b0;
        end
    endtask

    task automatic run_txn(input int tail_bits, input bit align);
        logic [7:0] rb;
        logic [7:0] ob;
        rx_q.delete();
        miso_q.delete();
        oe_q.delete();
        fin_cnt = 0;
        both_cnt = 0;
        read_data_in = 8'h00;
        cs_n = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < tx_q.size(); k++) begin
            if (k == tx_q.size() - 1) send_bits(tx_q[k], tail_bits, align, rb, ob);
            else send_bits(tx_q[k], 8, 1'b0, rb, ob);
            miso_q.push_back(rb);
            oe_q.push_back(ob);
        end
        repeat (2) tick();
        cs_n = 1'b1;
        repeat (6) tick();
    endtask

    // Expected results derived from the bytes the master sent and the responder rules.
    task automatic model_check(input string tag, input int tail_bits);
        int nfull;
        logic rd;
        logic [7:0] obs;
        logic [7:0] exp_m;
        nfull = (tail_bits == 8) ? tx_q.size() - 1 : tx_q.size() - 2;
        rd = tx_q[0][7];
        check($sformatf("%s.slave_id", tag), 32'(slave_id), 32'(tx_q[0][6:0]));
        check($sformatf("%s.rnw", tag), 32'(rnw), 32'(rd));
        check($sformatf("%s.valid_count", tag), 32'(rx_q.size()), 32'(nfull));
        check($sformatf("%s.finished_count", tag), 32'(fin_cnt), 32'd1);
        for (int k = 0; k < nfull; k++) begin
            obs = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
            check($sformatf("%s.rx%0d", tag, k), 32'(obs), 32'(tx_q[k+1]));
        end
        if (nfull > 0) check($sformatf("%s.data_in", tag), 32'(data_in), 32'(tx_q[nfull]));
        for (int k = 0; k <= nfull; k++) begin
            if (!rd || k < 2) exp_m = 8'h00;
            else exp_m = echo_mode ? (tx_q[k-1] ^ 8'h5A) : resp_val;
            check($sformatf("%s.oe%0d", tag, k), 32'(oe_q[k]), (rd && k >= 1) ? 32'h0FF : 32'h000);
            check($sformatf("%s.miso%0d", tag, k), 32'(miso_q[k]), 32'(exp_m));
        end
        check($sformatf("%s.oe_after", tag), 32'(miso_oe), 32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] ob;
        rst_n = 1'b0;
        sclk = 1'b0;
        mosi = 1'b0;
        cs_n = 1'b1;
        read_data_in = 8'h00;
        repeat (3) tick();
        check("rst.miso", 32'(miso), 32'd0);
        check("rst.miso_oe", 32'(miso_oe), 32'd0);
        check("rst.data_in", 32'(data_in), 32'd0);
        check("rst.valid", 32'(data_in_valid), 32'd0);
        check("rst.finished", 32'(data_in_finished), 32'd0);
        check("rst.slave_id", 32'(slave_id), 32'd0);
        check("rst.rnw", 32'(rnw), 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Plain write.
        tx_q = '{8'h03, 8'h12, 8'h34};
        run_txn(8, 1'b0);
        model_check("write", 8);

        // Read with a fixed responder value.
        resp_val = 8'hA5;
        tx_q = '{8'h83, 8'h05, 8'h00};
        run_txn(8, 1'b0);
        model_check("read", 8);

        // Transaction aborted five bits into the second data byte.
        tx_q = '{8'h03, 8'h12, 8'h34};
        run_txn(5, 1'b0);
        model_check("partial", 5);

        // Final rise and cs_n release land in the same synchroniser sample.
        tx_q = '{8'h03, 8'h56, 8'h78};
        run_txn(8, 1'b1);
        model_check("align", 8);
        check("align.same_cycle", 32'(both_cnt), 32'd1);
        tx_q = '{8'h07, 8'h9A};
        run_txn(8, 1'b0);
        model_check("restart", 8);

        // Asynchronous reset in the middle of a read data byte.
        tx_q = '{8'h85, 8'h11};
        run_txn(8, 1'b0);
        model_check("pre_reset", 8);
        rx_q.delete();
        fin_cnt = 0;
        cs_n = 1'b0;
        repeat (4) tick();
        send_bits(8'h81, 8, 1'b0, rb, ob);
        send_bits(8'hC3, 3, 1'b0, rb, ob);
        mosi = 1'b1;
        sclk = 1'b1;
        repeat (2) tick();
        check("midreset.oe_before", 32'(miso_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset.miso", 32'(miso), 32'd0);
        check("midreset.miso_oe", 32'(miso_oe), 32'd0);
        check("midreset.data_in", 32'(data_in), 32'd0);
        check("midreset.valid", 32'(data_in_valid), 32'd0);
        check("midreset.finished", 32'(data_in_finished), 32'd0);
        check("midreset.slave_id", 32'(slave_id), 32'd0);
        check("midreset.rnw", 32'(rnw), 32'd0);
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check("midreset.no_valid", 32'(rx_q.size()), 32'd0);
        check("midreset.no_finished", 32'(fin_cnt), 32'd0);
        tx_q = '{8'h03, 8'h12};
        run_txn(8, 1'b0);
        model_check("post_reset", 8);

        // Random traffic at clk/10 with the responder echoing each byte back.
        echo_mode = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tx_q.delete();
            tx_q.push_back({t[0], 7'($urandom)});
            for (int n = 0; n < 124; n++) tx_q.push_back(8'($urandom));
            run_txn(8, 1'b0);
            model_check($sformatf("rand%0d", t), 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
